// File: rtl/muldiv_iter.sv
// Iterative 32x32 multiply / 32/32 divide with HI/LO registers (mips789 EX stage).
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU decode as NOP.
module muldiv_iter #(
   parameter int ITER = 32
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        pause,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hilo_sel,
   output logic [31:0] res,
   output logic        busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [4:0] CNT_INIT = 5'(ITER - 1);

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [64:0] acc;      // mul: {carry, hi, multiplier}; div: {remainder, quotient}
   logic [31:0] opnd;     // |b|: multiplicand or divisor
   logic        neg_q;
   logic [31:0] hi, lo;

   logic        idle_ok;
   logic        is_mul, is_sgn;
   logic        accept;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [64:0] mul_next;
   logic [63:0] mul_fix;

   assign idle_ok  = (state == S_IDLE) && !pause;
   assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
   assign is_sgn   = (op == OP_MULT) || (op == OP_DIV);
   assign a_mag    = (is_sgn && a[31]) ? (32'd0 - a) : a;
   assign b_mag    = (is_sgn && b[31]) ? (32'd0 - b) : b;

   assign mul_sum  = acc[64:32] + (acc[0] ? {1'b0, opnd} : 33'd0);
   assign mul_next = {1'b0, mul_sum, acc[31:1]};
   assign mul_fix  = neg_q ? (64'd0 - acc[63:0]) : acc[63:0];

`ifdef MULDIV_DIV_EN
   logic        is_div;
   logic        run_div;
   logic        neg_r;
   logic        div0;
   logic [31:0] a_raw;
   logic [32:0] rem_sh;
   logic [33:0] diff;
   logic [64:0] div_next;
   logic [31:0] quo_fix, rem_fix;

   assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
   assign rem_sh   = {acc[63:32], acc[31]};
   assign diff     = {1'b0, rem_sh} - {2'b00, opnd};
   assign div_next = diff[33] ? {rem_sh, acc[30:0], 1'b0}
                              : {diff[32:0], acc[30:0], 1'b1};
   assign quo_fix  = neg_q ? (32'd0 - acc[31:0])  : acc[31:0];
   assign rem_fix  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
   assign accept   = idle_ok && (is_mul || is_div);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         run_div <= 1'b0;
         neg_r   <= 1'b0;
         div0    <= 1'b0;
         a_raw   <= 32'd0;
      end else if (accept) begin
         run_div <= is_div;
         neg_r   <= is_sgn && a[31];
         div0    <= (b == 32'd0);
         a_raw   <= a;
      end
   end
`else
   assign accept = idle_ok && is_mul;
`endif

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= 5'd0;
         acc   <= 65'd0;
         opnd  <= 32'd0;
         neg_q <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_RUN;
                  cnt   <= CNT_INIT;
                  acc   <= {33'd0, a_mag};
                  opnd  <= b_mag;
                  neg_q <= is_sgn && (a[31] ^ b[31]);
               end else if (idle_ok && op == OP_MTHI) begin
                  hi <= a;
               end else if (idle_ok && op == OP_MTLO) begin
                  lo <= a;
               end
            end
            S_RUN: begin
`ifdef MULDIV_DIV_EN
               acc <= run_div ? div_next : mul_next;
`else
               acc <= mul_next;
`endif
               if (cnt == 5'd0) state <= S_FIX;
               else             cnt   <= cnt - 5'd1;
            end
            S_FIX: begin
               state <= S_IDLE;
`ifdef MULDIV_DIV_EN
               if (run_div) begin
                  // divide by zero bypasses sign fixup: LO all ones, HI = dividend
                  lo <= div0 ? 32'hFFFF_FFFF : quo_fix;
                  hi <= div0 ? a_raw : rem_fix;
               end else begin
                  hi <= mul_fix[63:32];
                  lo <= mul_fix[31:0];
               end
`else
               hi <= mul_fix[63:32];
               lo <= mul_fix[31:0];
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign res  = hilo_sel ? hi : lo;

endmodule
